// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-scan debounce and single-key reporting
module keypad_scanner #(
  parameter int SCAN_DIV = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);
  // snap bit (col*4 + row) to hex code, bit 0 in the low nibble
  localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} clsKind_t;
  typedef enum logic [1:0] {IDLE, PRESSED, LOCKED} state_t;
  logic [3:0] rowMeta, rowSync;
  logic [1:0] colIdx;
  logic [DW-1:0] dwell;
  logic [15:0] snap;
  logic scanDone, lastDwell, sameCls, stableHit;
  logic [4:0] bitCount;
  clsKind_t curKind, prevKind;
  logic [3:0] curCode, prevCode, stable, nextStable;
  state_t state;
  assign lastDwell = dwell == DWELL_MAX;
  assign col = ~(4'b0001 << colIdx);
  always_ff @(posedge clk) begin
    if (!resetN) begin
      rowMeta <= 4'hF;
      rowSync <= 4'hF;
      colIdx <= '0;
      dwell <= '0;
      snap <= '0;
      scanDone <= 1'b0;
    end else begin
      rowMeta <= row;
      rowSync <= rowMeta;
      dwell <= lastDwell ? '0 : dwell + 1'b1;
      scanDone <= lastDwell && colIdx == 2'd3;
      if (lastDwell) begin
        snap[{colIdx, 2'b00} +: 4] <= ~rowSync;
        colIdx <= colIdx + 1'b1;
      end
    end
  end
  always_comb begin
    bitCount = '0;
    curCode = '0;
    for (int i = 0; i < 16; i++)
      if (snap[i]) begin
        bitCount = bitCount + 1'b1;
        curCode = KEY_MAP[i*4 +: 4];
      end
    curKind = bitCount == 5'd0 ? CLS_NONE : bitCount == 5'd1 ? CLS_SINGLE : CLS_MULTI;
    sameCls = curKind == prevKind && (curKind != CLS_SINGLE || curCode == prevCode);
    nextStable = sameCls ? (stable == STABLE_MAX ? stable : stable + 1'b1) : 4'd1;
    stableHit = nextStable == STABLE_MAX;
  end
  always_ff @(posedge clk) begin
    if (!resetN) begin
      stable <= '0;
      prevKind <= CLS_NONE;
      prevCode <= '0;
    end else if (scanDone) begin
      stable <= nextStable;
      prevKind <= curKind;
      prevCode <= curCode;
    end
  end
  // reporting reacts in the classification cycle so keyValid lands one cycle after the last sample
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      keyCode <= '0;
      keyValid <= 1'b0;
      keyHeld <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      if (scanDone && stableHit)
        case (state)
          IDLE:
            if (curKind == CLS_SINGLE) begin
              keyCode <= curCode;
              keyValid <= 1'b1;
              keyHeld <= 1'b1;
              state <= PRESSED;
            end
          PRESSED:
            if (curKind == CLS_NONE) begin
              keyHeld <= 1'b0;
              state <= IDLE;
            end else if (curKind == CLS_MULTI || curCode != keyCode) begin
              keyHeld <= 1'b0;
              state <= LOCKED;
            end
          LOCKED:
            if (curKind == CLS_NONE) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scan-level stimulus against a per-scan behavioural model, scoreboard-checked
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int SCAN = 4 * SD;
  typedef struct {int cyc; logic [3:0] code;} rep_t;
  typedef struct {int cyc; logic held;} held_t;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [3:0] row, col, keyCode;
  logic keyValid, keyHeld;
  logic [15:0] pressed = '0;
  logic [3:0] keyTable [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0}, '{4'h2, 4'h5, 4'h8, 4'hF},
                                  '{4'h3, 4'h6, 4'h9, 4'hE}, '{4'hA, 4'hB, 4'hC, 4'hD}};
  rep_t repQ[$];
  held_t heldQ[$];
  int checks = 0, errors = 0, cyc = 0, base = 0, scanIdx = 0;
  int prevCls = -1, runLen = 0, heldCode = 0;
  bit armed = 1'b1, heldExp = 1'b0, running = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .resetN(resetN), .row(row), .col(col),
    .keyCode(keyCode), .keyValid(keyValid), .keyHeld(keyHeld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col[c] == 1'b0 && pressed[c*4+r]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // one scan of the keypad: model decides the debounced outcome from the spec's rules
  task automatic runScan(input logic [15:0] p);
    int n, cls;
    n = $countones(p);
    cls = n == 0 ? -1 : -2;
    if (n == 1)
      for (int i = 0; i < 16; i++) if (p[i]) cls = int'(keyTable[i/4][i%4]);
    runLen = (cls == prevCls) ? runLen + 1 : 1;
    prevCls = cls;
    if (runLen >= DB) begin
      if (cls == -1) begin
        heldExp = 1'b0;
        armed = 1'b1;
      end else if (armed && cls >= 0) begin
        repQ.push_back('{SCAN * scanIdx + SCAN + 1, 4'(cls)});
        heldExp = 1'b1;
        armed = 1'b0;
        heldCode = cls;
      end else if (heldExp && cls != heldCode) heldExp = 1'b0;
    end
    heldQ.push_back('{SCAN * scanIdx + SCAN + 1, heldExp});
    pressed = p;
    scanIdx++;
    repeat (SCAN) @(posedge clk);
    #1;
  endtask

  task automatic runScans(input logic [15:0] p, input int n);
    repeat (n) runScan(p);
  endtask

  task automatic doReset();
    running = 1'b0;
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset col", col, 4'b1110);
    check("reset keyCode", keyCode, 4'h0);
    check("reset keyValid", keyValid, 1'b0);
    check("reset keyHeld", keyHeld, 1'b0);
    repQ.delete();
    heldQ.delete();
    prevCls = -1;
    runLen = 0;
    armed = 1'b1;
    heldExp = 1'b0;
    scanIdx = 0;
    resetN = 1'b1;
    base = cyc;
    running = 1'b1;
  endtask

  always @(negedge clk) begin
    if (running) begin
      int rel;
      logic [3:0] expCol;
      rep_t e;
      held_t h;
      rel = cyc - base;
      expCol = ~(4'b0001 << ((rel / SD) % 4));
      check("col", col, expCol);
      if (heldQ.size() > 0 && heldQ[0].cyc == rel) begin
        h = heldQ.pop_front();
        check("keyHeld", keyHeld, h.held);
      end
      if (keyValid) begin
        if (repQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected keyValid: code %0h at cycle %0d, expected no pulse", keyCode, rel);
        end else begin
          e = repQ.pop_front();
          check("keyValid cycle", rel, e.cyc);
          check("keyCode", keyCode, e.code);
          check("keyHeld at report", keyHeld, 1'b1);
        end
      end
    end
  end

  initial begin
    logic [15:0] p;
    int a, b, r;
    doReset();
    runScans(16'h0020, 13);
    runScans(16'h0000, 4);
    runScans(16'h0020, 1);
    runScans(16'h0000, 4);
    runScans(16'h8001, 5);
    runScans(16'h0000, 4);
    runScans(16'h8000, 4);
    runScans(16'h0000, 4);
    runScans(16'h0020, 4);
    runScans(16'h0400, 5);
    runScans(16'h0000, 4);
    runScans(16'h0400, 4);
    runScans(16'h0000, 4);
    runScans(16'h0100, 2);
    doReset();
    runScans(16'h0100, 4);
    runScans(16'h0000, 4);
    repeat (60) begin
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 15);
      b = (a + 1 + $urandom_range(0, 14)) % 16;
      p = '0;
      if (r >= 35) p[a] = 1'b1;
      if (r >= 80) p[b] = 1'b1;
      runScans(p, $urandom_range(1, 5));
    end
    runScans(16'h0000, 4);
    repeat (4) @(posedge clk);
    #1;
    check("pending reports", repQ.size(), 0);
    check("pending held checks", heldQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
